// File: rtl/pmu_counter_bank_if.sv
// Request/response handshake between the AXI bridge (master) and the PMU counter bank (slave).
// Level-held enables are answered with level valids in a 4-phase handshake.
interface pmu_counter_bank_if #(
    parameter int COUNTER_ADDRESS_WIDTH = 16,
    parameter int COUNTER_DATA_WIDTH    = 64
);
    logic                             counter_read_enable;
    logic [COUNTER_ADDRESS_WIDTH-1:0] counter_read_address;
    logic                             counter_read_valid;
    logic [COUNTER_DATA_WIDTH-1:0]    counter_read_data;
    logic                             counter_write_enable;
    logic [COUNTER_ADDRESS_WIDTH-1:0] counter_write_address;
    logic [COUNTER_DATA_WIDTH-1:0]    counter_write_data;
    logic                             counter_write_valid;

    modport master (
        output counter_read_enable, counter_read_address,
        output counter_write_enable, counter_write_address, counter_write_data,
        input  counter_read_valid, counter_read_data, counter_write_valid
    );

    modport slave (
        input  counter_read_enable, counter_read_address,
        input  counter_write_enable, counter_write_address, counter_write_data,
        output counter_read_valid, counter_read_data, counter_write_valid
    );
endinterface

// File: rtl/pmu_counter_bank.sv
// PMU event counter bank with CTRL/MASK/OVF registers behind a synchronized 4-phase handshake.
// Optional macro PMU_OVF_IRQ_EN adds CTRL.irq_en (bit2) and a registered overflow interrupt.
module pmu_counter_bank #(
    parameter int N_COUNTERS            = 16,
    parameter int COUNTER_ADDRESS_WIDTH = 16,
    parameter int COUNTER_DATA_WIDTH    = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [N_COUNTERS-1:0] events_i,
    pmu_counter_bank_if.slave     bus,
    output logic                  ovf_irq_o
);
    localparam int DW       = COUNTER_DATA_WIDTH;
    localparam int IDX_W    = COUNTER_ADDRESS_WIDTH - 3;
    localparam int CNT_BASE = 4;
    localparam logic [IDX_W-1:0] IDX_CTRL = IDX_W'(0);
    localparam logic [IDX_W-1:0] IDX_MASK = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_OVF  = IDX_W'(2);

    typedef enum logic {ST_IDLE = 1'b0, ST_ACK = 1'b1} hs_state_t;

    logic                  rd_en_meta, rd_en_s, wr_en_meta, wr_en_s;
    hs_state_t             rd_state, rd_state_nxt, wr_state, wr_state_nxt;
    logic                  rd_fire, wr_fire;
    logic [IDX_W-1:0]      rd_idx, wr_idx;
    logic [DW-1:0]         rd_value, rd_data_q, ctrl_rd;
    logic                  global_en_q;
    logic [N_COUNTERS-1:0] mask_q, ovf_q, ovf_w1c, ovf_set, cnt_inc, cnt_wr_sel;
    logic [DW-1:0]         cnt_q [N_COUNTERS];
    logic                  wr_ctrl, wr_mask, wr_ovf, clear_all;
    logic                  unused_addr_lsbs;
`ifdef PMU_OVF_IRQ_EN
    logic                  irq_en_q, irq_q;
`endif

    assign rd_idx           = bus.counter_read_address[COUNTER_ADDRESS_WIDTH-1:3];
    assign wr_idx           = bus.counter_write_address[COUNTER_ADDRESS_WIDTH-1:3];
    assign unused_addr_lsbs = ^{bus.counter_read_address[2:0], bus.counter_write_address[2:0]};

    // Enables cross from the AXI domain; address/data are stable while enable is high.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_en_meta <= 1'b0;
            rd_en_s    <= 1'b0;
            wr_en_meta <= 1'b0;
            wr_en_s    <= 1'b0;
        end else begin
            rd_en_meta <= bus.counter_read_enable;
            rd_en_s    <= rd_en_meta;
            wr_en_meta <= bus.counter_write_enable;
            wr_en_s    <= wr_en_meta;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_state <= ST_IDLE;
            wr_state <= ST_IDLE;
        end else begin
            rd_state <= rd_state_nxt;
            wr_state <= wr_state_nxt;
        end
    end

    always_comb begin
        rd_state_nxt = rd_state;
        wr_state_nxt = wr_state;
        case (rd_state)
            ST_IDLE: if (rd_en_s)  rd_state_nxt = ST_ACK;
            ST_ACK:  if (!rd_en_s) rd_state_nxt = ST_IDLE;
            default: rd_state_nxt = ST_IDLE;
        endcase
        case (wr_state)
            ST_IDLE: if (wr_en_s)  wr_state_nxt = ST_ACK;
            ST_ACK:  if (!wr_en_s) wr_state_nxt = ST_IDLE;
            default: wr_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.counter_read_valid  = (rd_state == ST_ACK);
        bus.counter_write_valid = (wr_state == ST_ACK);
        rd_fire                 = (rd_state == ST_IDLE) && rd_en_s;
        wr_fire                 = (wr_state == ST_IDLE) && wr_en_s;
    end

    always_comb begin
        ctrl_rd    = '0;
        ctrl_rd[0] = global_en_q;
`ifdef PMU_OVF_IRQ_EN
        ctrl_rd[2] = irq_en_q;
`endif
    end

    // Read mux sees pre-edge state, so a same-cycle write is not visible to the read.
    always_comb begin
        rd_value = '0;
        case (rd_idx)
            IDX_CTRL: rd_value = ctrl_rd;
            IDX_MASK: rd_value[N_COUNTERS-1:0] = mask_q;
            IDX_OVF:  rd_value[N_COUNTERS-1:0] = ovf_q;
            default: begin
                for (int i = 0; i < N_COUNTERS; i++) begin
                    if (rd_idx == IDX_W'(CNT_BASE + i)) rd_value = cnt_q[i];
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)        rd_data_q <= '0;
        else if (rd_fire) rd_data_q <= rd_value;
    end

    assign bus.counter_read_data = rd_data_q;

    always_comb begin
        wr_ctrl    = wr_fire && (wr_idx == IDX_CTRL);
        wr_mask    = wr_fire && (wr_idx == IDX_MASK);
        wr_ovf     = wr_fire && (wr_idx == IDX_OVF);
        clear_all  = wr_ctrl && bus.counter_write_data[1];
        ovf_w1c    = wr_ovf ? bus.counter_write_data[N_COUNTERS-1:0] : '0;
        cnt_wr_sel = '0;
        cnt_inc    = '0;
        ovf_set    = '0;
        for (int i = 0; i < N_COUNTERS; i++) begin
            cnt_wr_sel[i] = wr_fire && (wr_idx == IDX_W'(CNT_BASE + i));
            cnt_inc[i]    = global_en_q && mask_q[i] && events_i[i];
            // A wrap only counts when the increment actually lands.
            ovf_set[i]    = cnt_inc[i] && (cnt_q[i] == '1) && !clear_all && !cnt_wr_sel[i];
        end
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < N_COUNTERS; i++) begin
            if (rst_i || clear_all) cnt_q[i] <= '0;
            else if (cnt_wr_sel[i]) cnt_q[i] <= bus.counter_write_data;
            else if (cnt_inc[i])    cnt_q[i] <= cnt_q[i] + DW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            global_en_q <= 1'b0;
            mask_q      <= '0;
            ovf_q       <= '0;
`ifdef PMU_OVF_IRQ_EN
            irq_en_q    <= 1'b0;
`endif
        end else begin
            if (wr_ctrl) begin
                global_en_q <= bus.counter_write_data[0];
`ifdef PMU_OVF_IRQ_EN
                irq_en_q    <= bus.counter_write_data[2];
`endif
            end
            if (wr_mask) mask_q <= bus.counter_write_data[N_COUNTERS-1:0];
            ovf_q <= (ovf_q & ~ovf_w1c) | ovf_set;
        end
    end

`ifdef PMU_OVF_IRQ_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) irq_q <= 1'b0;
        else       irq_q <= irq_en_q && (|ovf_q);
    end
    assign ovf_irq_o = irq_q;
`else
    assign ovf_irq_o = 1'b0;
`endif
endmodule

// File: tb/tb_pmu_counter_bank.sv
// Randomized bench for pmu_counter_bank against a register-level model, plus literal checks.
module tb_pmu_counter_bank;
    localparam int N        = 16;
    localparam int AW       = 16;
    localparam int DW       = 64;
    localparam int CNT_BASE = 4;
`ifdef PMU_OVF_IRQ_EN
    localparam bit IRQ_BUILT = 1'b1;
`else
    localparam bit IRQ_BUILT = 1'b0;
`endif

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic [N-1:0] events_i = '0;
    logic         ovf_irq_o;

    pmu_counter_bank_if #(.COUNTER_ADDRESS_WIDTH(AW), .COUNTER_DATA_WIDTH(DW)) bus ();

    pmu_counter_bank #(
        .N_COUNTERS(N), .COUNTER_ADDRESS_WIDTH(AW), .COUNTER_DATA_WIDTH(DW)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .events_i(events_i), .bus(bus.slave), .ovf_irq_o(ovf_irq_o)
    );

    always #5 clk_i = ~clk_i;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_on = 1'b0;

    logic         ev_rand  = 1'b0;
    logic [N-1:0] ev_fixed = '0;

    // Register-level model of the bank
    logic [63:0]  m_cnt [N];
    logic [N-1:0] m_mask, m_ovf;
    logic         m_en, m_irq_en;
    logic         rd_h1, rd_h2, wr_h1, wr_h2;
    logic         exp_rvalid, exp_wvalid, exp_irq;
    logic [63:0]  exp_rdata;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] m_read(input logic [15:0] addr);
        int idx;
        idx = int'(addr) >> 3;
        if (idx == 0) return 64'(m_en) | (64'(m_irq_en) << 2);
        if (idx == 1) return 64'(m_mask);
        if (idx == 2) return 64'(m_ovf);
        if (idx >= CNT_BASE && idx < CNT_BASE + N) return m_cnt[idx - CNT_BASE];
        return 64'd0;
    endfunction

    // Valid after edge k equals the enable as sampled at edge k-2; rises mark the
    // cycle where the read snapshot is taken and the write lands.
    task automatic model_step();
        logic [N-1:0] inc, set_b, w1c;
        logic         new_rv, new_wv, clear, irq_next;
        logic [63:0]  wd;
        int           widx, wsel;
        if (rst_i) begin
            for (int i = 0; i < N; i++) m_cnt[i] = '0;
            m_mask = '0; m_ovf = '0; m_en = 1'b0; m_irq_en = 1'b0;
            rd_h1 = 1'b0; rd_h2 = 1'b0; wr_h1 = 1'b0; wr_h2 = 1'b0;
            exp_rvalid = 1'b0; exp_wvalid = 1'b0; exp_irq = 1'b0; exp_rdata = '0;
        end else begin
            new_rv   = rd_h2;
            new_wv   = wr_h2;
            irq_next = m_irq_en && (m_ovf != '0);
            inc      = m_en ? (m_mask & events_i) : '0;
            if (new_rv && !exp_rvalid) exp_rdata = m_read(bus.counter_read_address);
            clear = 1'b0; wsel = -1; w1c = '0; set_b = '0;
            wd = bus.counter_write_data;
            if (new_wv && !exp_wvalid) begin
                widx = int'(bus.counter_write_address) >> 3;
                if (widx == 0) begin
                    m_en = wd[0]; m_irq_en = IRQ_BUILT && wd[2]; clear = wd[1];
                end else if (widx == 1) m_mask = wd[N-1:0];
                else if (widx == 2) w1c = wd[N-1:0];
                else if (widx >= CNT_BASE && widx < CNT_BASE + N) wsel = widx - CNT_BASE;
            end
            for (int i = 0; i < N; i++) begin
                if (clear) m_cnt[i] = 64'd0;
                else if (i == wsel) m_cnt[i] = wd;
                else if (inc[i]) begin
                    if (m_cnt[i] == 64'hFFFF_FFFF_FFFF_FFFF) set_b[i] = 1'b1;
                    m_cnt[i] = m_cnt[i] + 64'd1;
                end
            end
            m_ovf      = (m_ovf & ~w1c) | set_b;
            exp_rvalid = new_rv;
            exp_wvalid = new_wv;
            exp_irq    = irq_next;
            rd_h2 = rd_h1; rd_h1 = bus.counter_read_enable;
            wr_h2 = wr_h1; wr_h1 = bus.counter_write_enable;
        end
    endtask

    initial forever begin
        @(posedge clk_i);
        model_step();
    end

    initial forever begin
        @(posedge clk_i);
        #2;
        events_i = (ev_rand ? N'($urandom) : '0) | ev_fixed;
    end

    initial forever begin
        @(negedge clk_i);
        if (chk_on) begin
            check("read_valid", 64'(bus.counter_read_valid), 64'(exp_rvalid));
            check("write_valid", 64'(bus.counter_write_valid), 64'(exp_wvalid));
            check("read_data", bus.counter_read_data, exp_rdata);
            check("ovf_irq", 64'(ovf_irq_o), 64'(exp_irq));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, n_chk=%0d", n_chk);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_read(input logic [15:0] addr, input int hold, output logic [63:0] data);
        bus.counter_read_address = addr;
        bus.counter_read_enable  = 1'b1;
        tick(); tick();
        check("rd_not_yet_valid", 64'(bus.counter_read_valid), 64'd0);
        tick();
        check("rd_valid_3_edges", 64'(bus.counter_read_valid), 64'd1);
        data = bus.counter_read_data;
        repeat (hold) tick();
        bus.counter_read_enable = 1'b0;
        tick(); tick();
        check("rd_valid_held", 64'(bus.counter_read_valid), 64'd1);
        tick();
        check("rd_valid_dropped", 64'(bus.counter_read_valid), 64'd0);
        tick();
    endtask

    task automatic do_write(input logic [15:0] addr, input logic [63:0] data,
                            input logic [N-1:0] ev_w, input int hold);
        ev_fixed                  = ev_w;
        bus.counter_write_address = addr;
        bus.counter_write_data    = data;
        bus.counter_write_enable  = 1'b1;
        tick(); tick();
        check("wr_not_yet_valid", 64'(bus.counter_write_valid), 64'd0);
        tick();
        check("wr_valid_3_edges", 64'(bus.counter_write_valid), 64'd1);
        ev_fixed = '0;
        repeat (hold) tick();
        bus.counter_write_enable = 1'b0;
        tick(); tick();
        check("wr_valid_held", 64'(bus.counter_write_valid), 64'd1);
        tick();
        check("wr_valid_dropped", 64'(bus.counter_write_valid), 64'd0);
        tick();
    endtask

    task automatic pulse(input logic [N-1:0] b, input int n);
        repeat (n) begin
            ev_fixed = b;
            tick();
            ev_fixed = '0;
            tick();
        end
    endtask

    function automatic logic [15:0] rand_addr();
        if ($urandom_range(0, 9) == 0) return 16'h0400 + 16'($urandom_range(0, 255));
        return 16'($urandom_range(0, (CNT_BASE + N + 1) * 8 - 1));
    endfunction

    function automatic logic [63:0] rand_data();
        if ($urandom_range(0, 3) == 0) return {60'hFFF_FFFF_FFFF_FFFF, 4'($urandom)};
        return {$urandom, $urandom};
    endfunction

    logic [63:0] d, d2;
    logic [15:0] a1, a2;
    logic [63:0] wdat;
    int          h1, h2, op;

    initial begin
        bus.counter_read_enable   = 1'b0;
        bus.counter_read_address  = '0;
        bus.counter_write_enable  = 1'b0;
        bus.counter_write_address = '0;
        bus.counter_write_data    = '0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i  = 1'b0;
        chk_on = 1'b1;
        check("reset_read_valid", 64'(bus.counter_read_valid), 64'd0);
        check("reset_write_valid", 64'(bus.counter_write_valid), 64'd0);
        check("reset_read_data", bus.counter_read_data, 64'd0);
        check("reset_irq", 64'(ovf_irq_o), 64'd0);

        do_read(16'h0000, 2, d); check("ctrl_after_reset", d, 64'd0);
        do_read(16'h0008, 0, d); check("mask_after_reset", d, 64'd0);
        do_read(16'h0010, 1, d); check("ovf_after_reset", d, 64'd0);
        do_read(16'h0020, 3, d); check("cnt0_after_reset", d, 64'd0);

        do_write(16'h0008, 64'h1, '0, 0);
        do_write(16'h0000, 64'h1, '0, 1);
        pulse(16'h0001, 5);
        pulse(16'h0002, 3);
        do_read(16'h0020, 0, d); check("cnt0_five_events", d, 64'd5);
        do_read(16'h0028, 0, d); check("cnt1_masked_off", d, 64'd0);

        do_write(16'h0000, 64'h5, '0, 0);
        do_read(16'h0000, 0, d); check("ctrl_irq_en_readback", d, IRQ_BUILT ? 64'h5 : 64'h1);
        do_write(16'h0020, 64'hFFFF_FFFF_FFFF_FFFE, '0, 0);
        pulse(16'h0001, 2);
        check("irq_after_wrap", 64'(ovf_irq_o), 64'(IRQ_BUILT));
        do_read(16'h0020, 0, d); check("cnt0_wrapped", d, 64'd0);
        do_read(16'h0010, 0, d); check("ovf_set_on_wrap", d, 64'h1);
        do_write(16'h0010, 64'h1, '0, 0);
        check("irq_after_w1c", 64'(ovf_irq_o), 64'd0);
        do_read(16'h0010, 0, d); check("ovf_w1c_cleared", d, 64'h0);

        do_write(16'h0020, 64'd100, 16'h0001, 0);
        do_read(16'h0020, 0, d); check("write_beats_increment", d, 64'd100);

        do_read(16'h0400, 0, d); check("unmapped_read_zero", d, 64'd0);
        do_write(16'h0400, 64'hDEAD, '0, 0);
        do_read(16'h0008, 0, d); check("mask_untouched", d, 64'h1);
        do_read(16'h0020, 0, d); check("cnt0_untouched", d, 64'd100);

        fork
            do_read(16'h0008, 1, d2);
            do_write(16'h0028, 64'd77, '0, 2);
        join
        check("concurrent_read", d2, 64'h1);
        do_read(16'h0028, 0, d); check("concurrent_write", d, 64'd77);

        do_write(16'h0000, 64'h3, '1, 0);
        do_read(16'h0020, 0, d); check("clear_all_cnt0", d, 64'd0);
        do_read(16'h0028, 0, d); check("clear_all_cnt1", d, 64'd0);
        do_read(16'h0000, 0, d); check("clear_all_self_clears", d, 64'h1);

        bus.counter_read_address = 16'h0020;
        bus.counter_read_enable  = 1'b1;
        repeat (4) tick();
        check("valid_before_reset", 64'(bus.counter_read_valid), 64'd1);
        rst_i = 1'b1;
        tick();
        check("valid_dropped_by_reset", 64'(bus.counter_read_valid), 64'd0);
        rst_i = 1'b0;
        bus.counter_read_enable = 1'b0;
        repeat (4) tick();
        do_read(16'h0008, 0, d); check("mask_after_mid_reset", d, 64'd0);

        ev_rand = 1'b1;
        for (int t = 0; t < 250; t++) begin
            op   = $urandom_range(0, 2);
            a1   = rand_addr();
            a2   = rand_addr();
            wdat = rand_data();
            h1   = $urandom_range(0, 3);
            h2   = $urandom_range(0, 3);
            if (op == 0) do_read(a1, h1, d);
            else if (op == 1) do_write(a2, wdat, '0, h2);
            else begin
                fork
                    do_read(a1, h1, d);
                    do_write(a2, wdat, '0, h2);
                join
            end
        end
        ev_rand = 1'b0;
        repeat (4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/pmu_counter_bank.md
Name: pmu_counter_bank

Overview:
- Responder end of the PMU counter read/write handshake. The AXI bridge initiates requests; this block serves them.
- Holds N event counters plus control/status registers.
- Answers level-held read/write enables with level valids using a 4-phase handshake.
- Sits in the core clock domain next to the Lagarto core's event sources. The enable inputs arrive from the AXI clock domain, so they are synchronized here.

Parameters:
- N_COUNTERS, 16, number of event counters (1..64).
- COUNTER_ADDRESS_WIDTH, 16, byte-address width of the request interface.
- COUNTER_DATA_WIDTH, 64, register and counter width.

Ports:
- clk_i  in  1  core clock
- rst_i  in  1  synchronous reset, active-high
- events_i  in  N_COUNTERS  one-cycle event pulses; bit i increments counter i
- counter_read_enable  in  1  read request level (async to clk_i)
- counter_read_address  in  COUNTER_ADDRESS_WIDTH  byte address, stable while enable is high
- counter_read_valid  out  1  read done, data stable
- counter_read_data  out  COUNTER_DATA_WIDTH  read data
- counter_write_enable  in  1  write request level (async)
- counter_write_address  in  COUNTER_ADDRESS_WIDTH  byte address, stable while enable is high
- counter_write_data  in  COUNTER_DATA_WIDTH  write data, stable while enable is high
- counter_write_valid  out  1  write done
- ovf_irq_o  out  1  overflow interrupt (see Optional Feature)

Behaviour:
- Clock and reset: one clock (clk_i); synchronous, active-high reset (rst_i).
- Reset values: all counters, CTRL, MASK, OVF = 0; counter_read_valid = 0; counter_write_valid = 0; counter_read_data = 0; ovf_irq_o = 0.
- Address map: index = address[COUNTER_ADDRESS_WIDTH-1:3]; address[2:0] is ignored.
  - 0x00 CTRL: bit0 global_en; bit1 clear_all, write-1 self-clearing, never reads back 1. Other bits read 0.
  - 0x08 MASK: per-counter enable bits [N_COUNTERS-1:0].
  - 0x10 OVF: sticky overflow bits; write-1-to-clear.
  - 0x18: reserved, reads 0.
  - 0x20 + 8*i: counter i, read/write.
  - Any other address: reads 0, writes ignored. Still acknowledged; no error path.
- Synchronization: each enable passes through a 2-flop synchronizer (rd_en_s, wr_en_s). Address and data are sampled directly; they are guaranteed stable while the enable is high.
- Read FSM (independent of write FSM):
  - IDLE: on rd_en_s = 1, capture register[addr] into counter_read_data and set counter_read_valid = 1 on the next edge; go to ACK.
  - ACK: hold valid and data while rd_en_s = 1. When rd_en_s = 0, clear valid on the next edge and go to IDLE. counter_read_data keeps its value.
  - A new request is only accepted from IDLE.
- Write FSM:
  - IDLE: on wr_en_s = 1, perform the write in that cycle, set counter_write_valid = 1 on the next edge; go to ACK.
  - ACK: same as the read FSM. Exactly one write occurs per request.
- Counting: counter i increments by 1 in a cycle when global_en & MASK[i] & events_i[i].
- Wrap-around: all-ones + 1 -> 0, and OVF[i] is set in the same edge.
- Simultaneous events, priority order:
  - clear_all beats everything: all counters go to 0; OVF is untouched.
  - A software write to counter i beats an increment of counter i in the same cycle.
  - OVF: a hardware set beats a W1C clear of the same bit in the same cycle.
  - A read and a write to the same register in the same cycle: the read returns the pre-write value.
- Mid-operation reset: both FSMs return to IDLE and valids drop immediately. The initiator sees valid low and must re-issue.
- Latency: enable rise to valid rise is 3 clk_i edges (2 sync + 1). Enable fall to valid fall is 3 edges.

Optional Feature:
- Macro PMU_OVF_IRQ_EN.
- Defined: CTRL bit2 = irq_en. ovf_irq_o is registered as irq_en & |OVF, and rises 1 cycle after an OVF bit sets. Clearing OVF via W1C drops it 1 cycle later.
- Undefined: ovf_irq_o is tied to 0; CTRL bit2 reads 0 and writes to it are ignored.

Test Plan:
- Reset, then read 0x00, 0x08, 0x10, 0x20 -> each returns 0; valid is 3 cycles after the enable rise and is held until the enable drops.
- Write MASK = 0x1, CTRL = 0x1, then pulse events_i[0] 5 times and events_i[1] 3 times; read 0x20 -> 5, read 0x28 -> 0.
- Write counter0 (0x20) = 0xFFFF_FFFF_FFFF_FFFE, then 2 events -> counter0 = 0; OVF reads 0x1; write OVF = 0x1 -> reads 0x0. With PMU_OVF_IRQ_EN and CTRL = 0x5, ovf_irq_o is 1 between the wrap and the clear.
- Write 0x20 = 100 in the same cycle as an event on counter0 -> read returns 100. Write CTRL = 0x3 during events -> all counters 0; CTRL reads 0x1.
- Read 0x400 -> 0 and acknowledged; write 0x400 = 0xDEAD -> acknowledged, no register changes. Concurrent read and write enables on different addresses both complete.
- Assert rst_i while in ACK -> valid drops on the next edge; a new request after reset completes normally.
